// File: rtl/result_tx_pkg.sv
// -----------------------------------------------------------------------------
// result_tx_pkg
// Shared definitions for the result UART transmitter:
//   - SYNC_BYTE_DEFAULT : first byte of every frame
//   - FRAME_BYTES       : bytes per frame (sync + 4 bytes of v0 + 4 bytes of v1)
//   - tx_state_e        : byte-level serialiser state encoding
//   - frame_byte()      : selects the byte at a given frame position
// -----------------------------------------------------------------------------
package result_tx_pkg;

    localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;
    localparam int         FRAME_BYTES       = 9;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_e;

    // Frame order: sync, v0 big-endian, v1 big-endian.
    function automatic logic [7:0] frame_byte(
        input logic [3:0]  idx,
        input logic [7:0]  sync,
        input logic [31:0] w0,
        input logic [31:0] w1
    );
        logic [7:0] b;
        case (idx)
            4'd0:    b = sync;
            4'd1:    b = w0[31:24];
            4'd2:    b = w0[23:16];
            4'd3:    b = w0[15:8];
            4'd4:    b = w0[7:0];
            4'd5:    b = w1[31:24];
            4'd6:    b = w1[23:16];
            4'd7:    b = w1[15:8];
            default: b = w1[7:0];
        endcase
        return b;
    endfunction

endpackage

// File: rtl/uart_byte_tx.sv
// -----------------------------------------------------------------------------
// uart_byte_tx
// Serialises one byte as UART 8N1 (start 0, 8 data bits LSB first, stop 1),
// each bit lasting CLKS_PER_BIT cycles.
// Ports:
//   Clk    in   system clock, rising edge
//   Reset  in   asynchronous active-high reset
//   Start  in   begin a byte; honoured in IDLE and in the last stop-bit cycle
//   Data   in   byte to send; must stay stable until Done
//   Tx     out  serial line, idles high
//   Done   out  high in the last cycle of the stop bit
// -----------------------------------------------------------------------------
module uart_byte_tx
    import result_tx_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       Start,
    input  logic [7:0] Data,
    output logic       Tx,
    output logic       Done
);

    localparam int               CNT_W     = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(CLKS_PER_BIT - 1);

    tx_state_e        state_q, state_d;
    logic [CNT_W-1:0] baud_q, baud_d;
    logic [2:0]       bit_idx_q, bit_idx_d;
    logic             bit_end;

    assign bit_end = (baud_q == BAUD_LAST);

    // State register
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q   <= IDLE;
            baud_q    <= '0;
            bit_idx_q <= '0;
        end else begin
            state_q   <= state_d;
            baud_q    <= baud_d;
            bit_idx_q <= bit_idx_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d   = state_q;
        baud_d    = baud_q;
        bit_idx_d = bit_idx_q;
        case (state_q)
            IDLE: begin
                if (Start) begin
                    state_d   = START;
                    baud_d    = '0;
                    bit_idx_d = '0;
                end
            end
            START: begin
                if (bit_end) begin
                    state_d = DATA;
                    baud_d  = '0;
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            DATA: begin
                if (bit_end) begin
                    baud_d = '0;
                    if (bit_idx_q == 3'd7) begin
                        state_d   = STOP;
                        bit_idx_d = '0;
                    end else begin
                        bit_idx_d = bit_idx_q + 1'b1;
                    end
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            STOP: begin
                if (bit_end) begin
                    baud_d = '0;
                    // Chaining straight into START keeps bytes of a frame gap-free.
                    state_d = Start ? START : IDLE;
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        Tx   = 1'b1;
        Done = 1'b0;
        case (state_q)
            START:   Tx = 1'b0;
            DATA:    Tx = Data[bit_idx_q];
            STOP:    Done = bit_end;
            default: ;
        endcase
    end

endmodule

// File: rtl/result_uart_tx.sv
// -----------------------------------------------------------------------------
// result_uart_tx
// Watches result registers v0/v1 and, whenever either differs from the last
// value sent, transmits a 9-byte UART frame: SYNC, v0 (MSB first), v1 (MSB
// first). Values changing while a frame is in flight are not sampled; only the
// value present when the transmitter returns to idle is considered.
// Ports:
//   Clk         in   system clock, rising edge
//   Reset       in   asynchronous active-high reset
//   v0, v1      in   result registers (32 bits each)
//   Tx          out  UART serial line, idles high
//   Busy        out  high while a frame is in flight
//   FrameCount  out  completed frames, modulo 256
// -----------------------------------------------------------------------------
module result_uart_tx
    import result_tx_pkg::*;
#(
    parameter int         CLKS_PER_BIT = 868,
    parameter logic [7:0] SYNC_BYTE    = SYNC_BYTE_DEFAULT
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic [31:0] v0,
    input  logic [31:0] v1,
    output logic        Tx,
    output logic        Busy,
    output logic [7:0]  FrameCount
);

    logic        busy_q, busy_d;
    logic [31:0] last_v0_q, last_v1_q;
    logic [31:0] snap_v0_q, snap_v1_q;
    logic [3:0]  byte_idx_q, byte_idx_d;
    logic [7:0]  frame_cnt_q, frame_cnt_d;

    logic        trigger;
    logic        last_byte;
    logic        byte_done;
    logic        byte_start;
    logic [7:0]  tx_byte;

    // Change detection is only armed while idle, so mid-frame changes are ignored.
    assign trigger    = !busy_q && ((v0 != last_v0_q) || (v1 != last_v1_q));
    assign last_byte  = (byte_idx_q == 4'(FRAME_BYTES - 1));
    assign byte_start = trigger || (byte_done && !last_byte);

    // Byte 0 is the constant sync byte, so it is valid before the snapshot lands.
    assign tx_byte = frame_byte(byte_idx_q, SYNC_BYTE, snap_v0_q, snap_v1_q);

    always_comb begin
        busy_d      = busy_q;
        byte_idx_d  = byte_idx_q;
        frame_cnt_d = frame_cnt_q;
        if (trigger) begin
            busy_d     = 1'b1;
            byte_idx_d = '0;
        end else if (byte_done) begin
            if (last_byte) begin
                busy_d      = 1'b0;
                frame_cnt_d = frame_cnt_q + 1'b1;
            end else begin
                byte_idx_d = byte_idx_q + 1'b1;
            end
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            busy_q      <= 1'b0;
            byte_idx_q  <= '0;
            frame_cnt_q <= '0;
            last_v0_q   <= '0;
            last_v1_q   <= '0;
            snap_v0_q   <= '0;
            snap_v1_q   <= '0;
        end else begin
            busy_q      <= busy_d;
            byte_idx_q  <= byte_idx_d;
            frame_cnt_q <= frame_cnt_d;
            if (trigger) begin
                snap_v0_q <= v0;
                snap_v1_q <= v1;
                last_v0_q <= v0;
                last_v1_q <= v1;
            end
        end
    end

    uart_byte_tx #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_byte_tx (
        .Clk   (Clk),
        .Reset (Reset),
        .Start (byte_start),
        .Data  (tx_byte),
        .Tx    (Tx),
        .Done  (byte_done)
    );

    assign Busy       = busy_q;
    assign FrameCount = frame_cnt_q;

endmodule

// File: tb/tb_result_uart_tx.sv
// -----------------------------------------------------------------------------
// tb_result_uart_tx
// Directed bench for result_uart_tx. Main instance runs at 4 clocks per bit;
// a second instance at 2 clocks per bit exercises FrameCount wrap-around.
// Tx is decoded by sampling the middle cycle of every bit.
// -----------------------------------------------------------------------------
module tb_result_uart_tx;

    localparam int CPB  = 4;
    localparam int CPB2 = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] v0, v1;
    logic        tx, busy;
    logic [7:0]  fc;

    logic [31:0] w0, w1;
    logic        tx2, busy2;
    logic [7:0]  fc2;

    int total = 0;
    int bad   = 0;

    logic [7:0] rx [9];
    int         stop_err;
    int         start_err;

    always #5 clk = ~clk;

    result_uart_tx #(.CLKS_PER_BIT(CPB), .SYNC_BYTE(8'hA5)) dut (
        .Clk(clk), .Reset(rst), .v0(v0), .v1(v1),
        .Tx(tx), .Busy(busy), .FrameCount(fc)
    );

    result_uart_tx #(.CLKS_PER_BIT(CPB2), .SYNC_BYTE(8'hA5)) dut2 (
        .Clk(clk), .Reset(rst), .v0(w0), .v1(w1),
        .Tx(tx2), .Busy(busy2), .FrameCount(fc2)
    );

    initial begin
        #3000000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end

    // Wait (bounded) for Tx low; returns at the negedge of the first start-bit cycle.
    task automatic wait_start(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (tx === 1'b0) begin
                ok = 1'b1;
                return;
            end
        end
    endtask

    // Called at the negedge of the first start-bit cycle; ends at the negedge
    // of the last stop-bit cycle of byte 8.
    task automatic recv_frame();
        logic [9:0] bits;
        stop_err  = 0;
        start_err = 0;
        bits      = '0;
        for (int b = 0; b < 9; b++) begin
            for (int k = 0; k < 10; k++) begin
                for (int c = 0; c < CPB; c++) begin
                    if (!(b == 0 && k == 0 && c == 0)) @(negedge clk);
                    if (c == CPB / 2) bits[k] = tx;
                    if (k == 9 && tx !== 1'b1) stop_err++;
                    if (k == 0 && tx !== 1'b0) start_err++;
                end
            end
            rx[b] = bits[8:1];
        end
    endtask

    task automatic test_reset();
        int errs;
        rst = 1'b1;
        v0 = '0; v1 = '0; w0 = '0; w1 = '0;
        repeat (3) @(negedge clk);
        total++;
        if (tx !== 1'b1 || busy !== 1'b0 || fc !== 8'd0 || tx2 !== 1'b1) begin
            bad++;
            $display("FAIL reset_hold tx=%b busy=%b fc=%0d tx2=%b want tx=1 busy=0 fc=0 tx2=1", tx, busy, fc, tx2);
        end
        rst  = 1'b0;
        errs = 0;
        repeat (1000) begin
            @(negedge clk);
            if (tx !== 1'b1 || busy !== 1'b0 || fc !== 8'd0 || busy2 !== 1'b0) errs++;
        end
        total++;
        if (errs !== 0) begin
            bad++;
            $display("FAIL reset_idle bad_cycles=%0d want 0", errs);
        end
    endtask

    task automatic test_first_frame();
        logic [7:0] exp_b [9];
        exp_b = '{8'hA5, 8'h00, 8'h00, 8'h00, 8'h12, 8'h00, 8'h00, 8'h00, 8'h34};
        @(negedge clk);
        v0 = 32'h0000_0012; v1 = 32'h0000_0034;
        @(negedge clk);
        total++;
        if (tx !== 1'b0 || busy !== 1'b1) begin
            bad++;
            $display("FAIL first_latency tx=%b busy=%b want tx=0 busy=1", tx, busy);
        end
        fork
            recv_frame();
            begin
                repeat (60) @(negedge clk);
                v0 = 32'h0000_0056;
                repeat (100) @(negedge clk);
                v0 = 32'h0000_0078;
            end
        join
        total++;
        if (busy !== 1'b1) begin
            bad++;
            $display("FAIL first_busy_end busy=%b want 1 at last stop cycle", busy);
        end
        @(negedge clk);
        total++;
        if (busy !== 1'b0 || tx !== 1'b1 || fc !== 8'd1) begin
            bad++;
            $display("FAIL first_done busy=%b tx=%b fc=%0d want busy=0 tx=1 fc=1", busy, tx, fc);
        end
        for (int i = 0; i < 9; i++) begin
            total++;
            if (rx[i] !== exp_b[i]) begin
                bad++;
                $display("FAIL first_byte%0d got=%02h want=%02h", i, rx[i], exp_b[i]);
            end
        end
        total++;
        if (stop_err !== 0 || start_err !== 0) begin
            bad++;
            $display("FAIL first_framing stop_err=%0d start_err=%0d want 0 0", stop_err, start_err);
        end
    endtask

    task automatic test_latest_only();
        logic [7:0] exp_b [9];
        bit ok;
        int errs;
        exp_b = '{8'hA5, 8'h00, 8'h00, 8'h00, 8'h78, 8'h00, 8'h00, 8'h00, 8'h34};
        wait_start(5, ok);
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL latest_start got=no_start want=start_within_5");
        end
        recv_frame();
        for (int i = 0; i < 9; i++) begin
            total++;
            if (rx[i] !== exp_b[i]) begin
                bad++;
                $display("FAIL latest_byte%0d got=%02h want=%02h", i, rx[i], exp_b[i]);
            end
        end
        @(negedge clk);
        total++;
        if (fc !== 8'd2 || busy !== 1'b0 || stop_err !== 0) begin
            bad++;
            $display("FAIL latest_done fc=%0d busy=%b stop_err=%0d want fc=2 busy=0 stop_err=0", fc, busy, stop_err);
        end
        errs = 0;
        repeat (200) begin
            @(negedge clk);
            if (busy !== 1'b0 || tx !== 1'b1) errs++;
        end
        total++;
        if (errs !== 0) begin
            bad++;
            $display("FAIL latest_no_extra busy_cycles=%0d want 0", errs);
        end
    endtask

    task automatic test_reset_midframe();
        logic [7:0] exp_b [9];
        bit ok;
        exp_b = '{8'hA5, 8'h00, 8'h00, 8'h00, 8'h78, 8'h00, 8'h00, 8'h00, 8'h00};
        @(negedge clk);
        v1 = 32'h0000_00AB;
        wait_start(5, ok);
        repeat (130) @(negedge clk);
        total++;
        if (busy !== 1'b1) begin
            bad++;
            $display("FAIL midreset_inflight busy=%b want 1", busy);
        end
        #1 rst = 1'b1;
        #1;
        total++;
        if (tx !== 1'b1 || busy !== 1'b0 || fc !== 8'd0) begin
            bad++;
            $display("FAIL midreset_async tx=%b busy=%b fc=%0d want tx=1 busy=0 fc=0", tx, busy, fc);
        end
        v1 = 32'h0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        wait_start(5, ok);
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL midreset_restart got=no_start want=start_within_5");
        end
        recv_frame();
        for (int i = 0; i < 9; i++) begin
            total++;
            if (rx[i] !== exp_b[i]) begin
                bad++;
                $display("FAIL midreset_byte%0d got=%02h want=%02h", i, rx[i], exp_b[i]);
            end
        end
        @(negedge clk);
        total++;
        if (fc !== 8'd1) begin
            bad++;
            $display("FAIL midreset_count fc=%0d want 1", fc);
        end
    endtask

    task automatic test_same_cycle();
        logic [7:0] exp_b [9];
        bit ok;
        int errs;
        exp_b = '{8'hA5, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
        @(negedge clk);
        v0 = 32'h0102_0304; v1 = 32'h0506_0708;
        wait_start(5, ok);
        recv_frame();
        for (int i = 0; i < 9; i++) begin
            total++;
            if (rx[i] !== exp_b[i]) begin
                bad++;
                $display("FAIL same_byte%0d got=%02h want=%02h", i, rx[i], exp_b[i]);
            end
        end
        @(negedge clk);
        errs = 0;
        repeat (200) begin
            @(negedge clk);
            if (busy !== 1'b0) errs++;
        end
        total++;
        if (fc !== 8'd2 || errs !== 0) begin
            bad++;
            $display("FAIL same_single fc=%0d extra_busy=%0d want fc=2 extra_busy=0", fc, errs);
        end
    endtask

    task automatic test_pulse_revert();
        logic [7:0] exp_b [9];
        bit ok;
        int errs;
        exp_b = '{8'hA5, 8'hCA, 8'hFE, 8'hBA, 8'hBE, 8'h05, 8'h06, 8'h07, 8'h08};
        @(negedge clk);
        v0 = 32'hCAFE_BABE;
        wait_start(5, ok);
        fork
            recv_frame();
            begin
                repeat (40) @(negedge clk);
                v1 = 32'hDEAD_BEEF;
                repeat (40) @(negedge clk);
                v1 = 32'h0506_0708;
            end
        join
        for (int i = 0; i < 9; i++) begin
            total++;
            if (rx[i] !== exp_b[i]) begin
                bad++;
                $display("FAIL pulse_byte%0d got=%02h want=%02h", i, rx[i], exp_b[i]);
            end
        end
        @(negedge clk);
        errs = 0;
        repeat (200) begin
            @(negedge clk);
            if (busy !== 1'b0 || tx !== 1'b1) errs++;
        end
        total++;
        if (fc !== 8'd3 || errs !== 0) begin
            bad++;
            $display("FAIL pulse_no_frame fc=%0d extra_busy=%0d want fc=3 extra_busy=0", fc, errs);
        end
    endtask

    task automatic test_wrap();
        int errs;
        int timeouts;
        int n;
        errs     = 0;
        timeouts = 0;
        for (int i = 1; i <= 256; i++) begin
            @(negedge clk);
            w0 = 32'(i);
            n  = 0;
            do begin
                @(negedge clk);
                n++;
            end while (busy2 !== 1'b1 && n < 5);
            while (busy2 === 1'b1 && n < 400) begin
                @(negedge clk);
                n++;
            end
            if (n >= 400 || busy2 !== 1'b0) timeouts++;
            if (fc2 !== 8'(i)) errs++;
            if (i == 255) begin
                total++;
                if (fc2 !== 8'hFF) begin
                    bad++;
                    $display("FAIL wrap_255 fc=%0d want 255", fc2);
                end
            end
        end
        total++;
        if (fc2 !== 8'd0 || tx2 !== 1'b1) begin
            bad++;
            $display("FAIL wrap_zero fc=%0d tx=%b want fc=0 tx=1", fc2, tx2);
        end
        total++;
        if (errs !== 0 || timeouts !== 0) begin
            bad++;
            $display("FAIL wrap_steps count_errs=%0d timeouts=%0d want 0 0", errs, timeouts);
        end
    endtask

    initial begin
        test_reset();
        test_first_frame();
        test_latest_only();
        test_reset_midframe();
        test_same_cycle();
        test_pulse_revert();
        test_wrap();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
